// File: rtl/board_shuffler.sv
// Memory-game board builder: 8 pair values shuffled into a 4x4 board by an
// iterative Fisher-Yates walk driven by a free-running 16-bit LFSR.
module board_shuffler #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [79:0] card_flat
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  LAST_TRY = 8'(MAX_TRIES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INIT   = 2'd1;
    localparam logic [1:0] S_SWAP   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    function automatic logic [15:0][2:0] identity_board();
        logic [15:0][2:0] b;
        for (int k = 0; k < 16; k++) b[k] = 3'(k >> 1);
        return b;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        tries_q, tries_d;
    logic              valid_q, valid_d;
    logic [15:0][2:0]  board_q, board_d;
    logic [3:0]        draw;
    logic [3:0]        partner;
    logic              take;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = state_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        valid_d = valid_q;
        board_d = board_q;
        draw    = lfsr_q[3:0];
        take    = (draw <= idx_q) || (tries_q == LAST_TRY);
        // Out-of-range draws fall back to slot 0 once the retry budget is spent.
        partner = (draw <= idx_q) ? draw : 4'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    valid_d = 1'b0;
                end
            end
            S_INIT: begin
                board_d = identity_board();
                idx_d   = 4'd15;
                tries_d = 8'd0;
                state_d = S_SWAP;
            end
            S_SWAP: begin
                if (take) begin
                    board_d[idx_q]   = board_q[partner];
                    board_d[partner] = board_q[idx_q];
                    tries_d          = 8'd0;
                    idx_d            = idx_q - 4'd1;
                    if (idx_q == 4'd1) begin
                        state_d = S_FINISH;
                        valid_d = 1'b1;
                    end
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            idx_q   <= 4'd0;
            tries_q <= 8'd0;
            valid_q <= 1'b0;
            board_q <= identity_board();
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            valid_q <= valid_d;
            board_q <= board_d;
        end
    end

    assign busy  = (state_q == S_INIT) || (state_q == S_SWAP);
    assign done  = (state_q == S_FINISH);
    assign valid = valid_q;

    for (genvar k = 0; k < 16; k++) begin : g_flat
        assign card_flat[k*5 +: 5] = {2'b00, board_q[k]};
    end

endmodule

// File: tb/tb_board_shuffler.sv
// Self-checking bench for board_shuffler: MAX_TRIES=8 and MAX_TRIES=1 instances
// compared against a plain array-based Fisher-Yates model.
module tb_board_shuffler;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        busy, done, valid, busy1, done1, valid1;
    logic [79:0] card, card1;
    logic [79:0] ident;
    logic [15:0] ref_lfsr;
    int          checks = 0;
    int          errors = 0;

    board_shuffler #(.SEED(SEED), .MAX_TRIES(8)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .valid(valid), .card_flat(card)
    );

    board_shuffler #(.SEED(SEED), .MAX_TRIES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .busy(busy1), .done(done1), .valid(valid1), .card_flat(card1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nx(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // ref_lfsr always holds the LFSR value the DUT shows during the current cycle.
    task automatic tick();
        @(posedge clk);
        ref_lfsr = reset ? nx(ref_lfsr) : SEED;
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pairs_ok(input logic [79:0] c);
        int cnt[8];
        logic [4:0] e;
        for (int v = 0; v < 8; v++) cnt[v] = 0;
        for (int k = 0; k < 16; k++) begin
            e = c[k*5 +: 5];
            if (e > 5'd7) return 1'b0;
            cnt[e[2:0]]++;
        end
        for (int v = 0; v < 8; v++) if (cnt[v] != 2) return 1'b0;
        return 1'b1;
    endfunction

    // l0: LFSR value in the cycle start is sampled; lat: cycles from start to done.
    task automatic predict(input logic [15:0] l0, input int mt,
                           output logic [79:0] brd, output int lat);
        int b[16];
        int i, j, tries, t;
        logic [15:0] l;
        for (int k = 0; k < 16; k++) b[k] = k / 2;
        l = nx(nx(l0));
        lat = 1;
        i = 15;
        tries = 0;
        while (i >= 1) begin
            lat++;
            j = int'(l[3:0]);
            if (j <= i) begin
                t = b[i]; b[i] = b[j]; b[j] = t;
                i--; tries = 0;
            end else if (tries == mt - 1) begin
                t = b[i]; b[i] = b[0]; b[0] = t;
                i--; tries = 0;
            end else begin
                tries++;
            end
            l = nx(l);
        end
        lat++;
        brd = '0;
        for (int k = 0; k < 16; k++) brd[k*5 +: 5] = 5'(b[k]);
    endtask

    task automatic do_reset();
        start = 1'b0;
        start1 = 1'b0;
        reset = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
    endtask

    // extra_at: cycle offset (after start) of a second start pulse, -1 for none.
    task automatic build(input int extra_at, output logic [79:0] b8, output int lat8,
                         output logic [15:0] l0);
        logic [79:0] p8, p1, b1;
        int e8, e1, n, nd8, nd1, lat1;
        start = 1'b1;
        start1 = 1'b1;
        l0 = ref_lfsr;
        predict(l0, 8, p8, e8);
        predict(l0, 1, p1, e1);
        tick();
        start = 1'b0;
        start1 = 1'b0;
        check("busy_after_start", {busy, valid, busy1, valid1}, 4'b1010);
        n = 1; lat8 = -1; lat1 = -1; nd8 = 0; nd1 = 0;
        b8 = 'x; b1 = 'x;
        while (n < 200 && !(lat8 >= 0 && lat1 >= 0)) begin
            if (done) begin
                nd8++;
                if (lat8 < 0) begin
                    lat8 = n; b8 = card;
                    check("valid_with_done", {valid, busy}, 2'b10);
                end
            end
            if (done1) begin
                nd1++;
                if (lat1 < 0) begin lat1 = n; b1 = card1; end
            end
            start  = (n == extra_at);
            start1 = (n == extra_at) && (n <= e1);
            tick();
            n++;
        end
        start = 1'b0;
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done) nd8++;
            if (done1) nd1++;
            tick();
        end
        check("latency8", lat8, e8);
        check("latency1", lat1, e1);
        check("board8", b8, p8);
        check("board1", b1, p1);
        check("pairs8", pairs_ok(b8), 1'b1);
        check("pairs1", pairs_ok(b1), 1'b1);
        check("done_pulses", {nd8[7:0], nd1[7:0]}, 16'h0101);
        check("idle_after", {busy, busy1, valid, valid1, done, done1}, 6'b001100);
        check("hold_board8", card, p8);
    endtask

    initial begin
        logic [79:0] b_a, b_b, b_c, b_x, p_a, p_c;
        logic [15:0] l_a, l_c, l_x;
        int lat_a, lat_b, lat_c, lat_x, pl;
        int zeros, mism;

        for (int k = 0; k < 16; k++) ident[k*5 +: 5] = 5'(k / 2);

        do_reset();
        check("reset_ctrl", {busy, done, valid, busy1, done1, valid1}, 6'b0);
        check("reset_board", card, ident);
        check("reset_board1", card1, ident);

        // Single build, start at cycle 10 after reset release.
        repeat (9) tick();
        build(-1, b_a, lat_a, l_a);
        check("lat_range", (lat_a >= 17 && lat_a <= 122), 1'b1);

        // Same start cycle reproduces board and latency.
        do_reset();
        repeat (9) tick();
        build(-1, b_b, lat_b, l_x);
        check("determ_board", b_b, b_a);
        check("determ_lat", lat_b, lat_a);

        // One cycle later: model decides whether the board changes.
        do_reset();
        repeat (10) tick();
        build(-1, b_c, lat_c, l_c);
        predict(l_a, 8, p_a, pl);
        predict(l_c, 8, p_c, pl);
        check("shift_differs", (b_c !== b_a), (p_c !== p_a));

        // Start while busy is ignored.
        do_reset();
        repeat (9) tick();
        build(5, b_x, lat_x, l_x);
        check("ign_busy_board", b_x, b_a);
        check("ign_busy_lat", lat_x, lat_a);

        // Start in the done cycle is ignored.
        do_reset();
        repeat (9) tick();
        build(lat_a, b_x, lat_x, l_x);
        check("ign_done_board", b_x, b_a);
        check("ign_done_lat", lat_x, lat_a);

        // Reset in the middle of SWAP.
        start = 1'b1;
        start1 = 1'b1;
        tick();
        start = 1'b0;
        start1 = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        tick();
        check("midrst_ctrl", {busy, valid, done, busy1, valid1, done1}, 6'b0);
        check("midrst_board", card, ident);
        reset = 1'b1;
        tick();
        build(-1, b_x, lat_x, l_x);

        // Randomized gaps and stray start pulses.
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 7)) tick();
            build(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : -1,
                  b_x, lat_x, l_x);
        end

        // Long idle run: LFSR follows the model and never hits zero.
        do_reset();
        zeros = 0;
        mism = 0;
        for (int c = 0; c < 70000; c++) begin
            tick();
            if (u_dut.lfsr_q == 16'h0) zeros++;
            if (u_dut.lfsr_q !== ref_lfsr) mism++;
        end
        check("lfsr_nonzero", zeros, 0);
        check("lfsr_sequence", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
